// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Resolves data-memory stalls, EX-resolved mispredicts, load-use hazards and
// fetch misses into PC / IF/ID / ID/EX control, with a data-memory watchdog
// and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_br_valid_i,
  input  logic             ex_br_taken_i,
  input  logic [31:0]      ex_br_target_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_pred_taken_i,
  input  logic [31:0]      ex_pred_pc_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  input  logic             imem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             freeze_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o
);

  localparam int                WD_W    = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(DMEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic {RUN, DWAIT} state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            dmiss, mispred, ldu, rs1_hit, rs2_hit;
  logic            stall_cyc;
  logic [31:0]     pc_plus4;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign dmiss   = mem_req_i & ~dmem_ready_i;

  // A taken branch is mispredicted also when the BTB guessed taken but to the
  // wrong target; a not-taken branch only cares about the direction bit.
  assign mispred = ex_br_valid_i &
                   ((ex_pred_taken_i != ex_br_taken_i) |
                    (ex_br_taken_i & (ex_pred_pc_i != ex_br_target_i)));

  assign rs1_hit = id_rs1_use_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_rs2_use_i & (id_rs2_i == ex_rd_i);
  assign ldu     = ex_is_load_i & (ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);

  // 32-bit wrap is intended: the fall-through of 0xFFFFFFFC is 0.
  assign pc_plus4      = ex_pc_i + 32'd4;
  assign redirect_pc_o = (redirect_o & ex_br_taken_i) ? ex_br_target_i : pc_plus4;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // Tracks whether the current data access has already been waiting a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM: next-state logic; stay in DWAIT only while the miss persists.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (dmiss)  state_d = DWAIT;
      DWAIT:   if (!dmiss) state_d = RUN;
      default:             state_d = RUN;
    endcase
  end

  // FSM: output logic; fixed priority dmiss > mispred > ldu > fetch miss.
  always_comb begin
    pc_en_o       = 1'b1;
    if_id_en_o    = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    freeze_o      = 1'b0;
    redirect_o    = 1'b0;
    stall_cyc     = 1'b0;
    if (rst_i) begin
      // Hold fetch and keep both front-end registers bubbled during reset.
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (dmiss) begin
      // Whole pipe holds; a branch in EX is re-evaluated once memory answers.
      freeze_o      = 1'b1;
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      stall_cyc     = 1'b1;
    end else if (mispred) begin
      redirect_o    = 1'b1;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (ldu) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
      stall_cyc     = 1'b1;
    end else if (!imem_ready_i) begin
      // IF/ID still moves into ID/EX; only the fetch side bubbles.
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      if_id_flush_o = 1'b1;
      stall_cyc     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  // Counts cycles spent in DWAIT, saturating at the timeout value.
  always_comb begin
    wd_d = wd_q;
    if (state_q == RUN)    wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
  end

  // Watchdog register and sticky timeout flag; the FSM keeps waiting after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_o <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_d == WD_MAX) timeout_o <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  // Saturating counts of stall cycles and redirects.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_cyc && stall_cnt_o != CNT_MAX)  stall_cnt_o <= stall_cnt_o + 1'b1;
      if (redirect_o && flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int TMO   = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_rs1_use_i, id_rs2_use_i, ex_is_load_i;
  logic        ex_br_valid_i, ex_br_taken_i, ex_pred_taken_i;
  logic [31:0] ex_br_target_i, ex_pc_i, ex_pred_pc_i;
  logic        mem_req_i, dmem_ready_i, imem_ready_i;
  logic        pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, freeze_o, redirect_o;
  logic [31:0] redirect_pc_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_wait;
  int m_wd, m_stall, m_flush;
  bit m_to;
  // model expectations for the current cycle
  bit e_pc_en, e_ifid_en, e_ifid_fl, e_idex_fl, e_frz, e_redir, e_dm, e_stall;
  logic [31:0] e_rpc;

  hazard_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TMO)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
    .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_br_valid_i(ex_br_valid_i), .ex_br_taken_i(ex_br_taken_i),
    .ex_br_target_i(ex_br_target_i), .ex_pc_i(ex_pc_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_pc_i(ex_pred_pc_i),
    .mem_req_i(mem_req_i), .dmem_ready_i(dmem_ready_i), .imem_ready_i(imem_ready_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_flush_o(id_ex_flush_o), .freeze_o(freeze_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_wd = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  // What the pipeline should do this cycle, from the hazard rules.
  task automatic model_comb();
    bit mp, hz;
    e_dm = mem_req_i && !dmem_ready_i;
    mp = ex_br_valid_i && ((ex_br_taken_i != ex_pred_taken_i) ||
                           (ex_br_taken_i && ex_pred_pc_i != ex_br_target_i));
    hz = ex_is_load_i && ex_rd_i != 0 &&
         ((id_rs1_use_i && id_rs1_i == ex_rd_i) || (id_rs2_use_i && id_rs2_i == ex_rd_i));
    e_pc_en = 1; e_ifid_en = 1; e_ifid_fl = 0; e_idex_fl = 0;
    e_frz = 0; e_redir = 0; e_stall = 0;
    e_rpc = ex_br_taken_i ? ex_br_target_i : ex_pc_i + 32'd4;
    if (rst_i) begin
      e_pc_en = 0; e_ifid_en = 0; e_ifid_fl = 1; e_idex_fl = 1;
    end else if (e_dm) begin
      e_frz = 1; e_pc_en = 0; e_ifid_en = 0; e_stall = 1;
    end else if (mp) begin
      e_redir = 1; e_ifid_fl = 1; e_idex_fl = 1;
    end else if (hz) begin
      e_pc_en = 0; e_ifid_en = 0; e_idex_fl = 1; e_stall = 1;
    end else if (!imem_ready_i) begin
      e_pc_en = 0; e_ifid_en = 0; e_ifid_fl = 1; e_stall = 1;
    end
  endtask

  // Advance model state across a rising edge.
  task automatic model_seq();
    if (m_wait) m_wd = (m_wd + 1 > TMO) ? TMO : m_wd + 1;
    else        m_wd = 0;
    if (m_wd == TMO) m_to = 1;
    m_wait = e_dm;
    if (e_stall && m_stall < CMAX) m_stall++;
    if (e_redir && m_flush < CMAX) m_flush++;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(m_flush));
    chk({tag, ".timeout"},   32'(timeout_o),   32'(m_to));
  endtask

  // One clock cycle: check comb outputs, take the edge, check registers.
  task automatic cycle(input string tag);
    #1;
    model_comb();
    chk({tag, ".pc_en"},    32'(pc_en_o),       32'(e_pc_en));
    chk({tag, ".ifid_en"},  32'(if_id_en_o),    32'(e_ifid_en));
    chk({tag, ".ifid_fl"},  32'(if_id_flush_o), 32'(e_ifid_fl));
    chk({tag, ".idex_fl"},  32'(id_ex_flush_o), 32'(e_idex_fl));
    chk({tag, ".freeze"},   32'(freeze_o),      32'(e_frz));
    chk({tag, ".redirect"}, 32'(redirect_o),    32'(e_redir));
    if (e_redir) chk({tag, ".rpc"}, redirect_pc_o, e_rpc);
    @(posedge clk_i);
    if (!rst_i) model_seq();
    @(negedge clk_i);
    chk_regs(tag);
  endtask

  task automatic idle();
    id_rs1_i = 0; id_rs2_i = 0; id_rs1_use_i = 0; id_rs2_use_i = 0;
    ex_rd_i = 0; ex_is_load_i = 0;
    ex_br_valid_i = 0; ex_br_taken_i = 0; ex_pred_taken_i = 0;
    ex_br_target_i = 0; ex_pc_i = 32'h1000; ex_pred_pc_i = 0;
    mem_req_i = 0; dmem_ready_i = 1; imem_ready_i = 1;
  endtask

  task automatic do_reset();
    rst_i = 1; model_reset();
    cycle("reset");
    rst_i = 0;
  endtask

  task automatic set_ldu(input logic [4:0] rd);
    ex_is_load_i = 1; ex_rd_i = rd; id_rs2_i = 5; id_rs2_use_i = 1;
  endtask

  initial begin
    idle();
    rst_i = 1; model_reset();
    @(negedge clk_i);
    do_reset();
    chk("rst.stall_zero", 32'(stall_cnt_o), 0);

    // load-use: exactly one stall cycle, then the load has left EX
    set_ldu(5'd5);
    cycle("ldu");
    idle();
    cycle("ldu_after");
    chk("ldu.cnt_one", 32'(stall_cnt_o), 1);
    set_ldu(5'd0);
    cycle("ldu_x0");
    idle();

    // mispredicts
    ex_br_valid_i = 1; ex_br_taken_i = 1; ex_br_target_i = 32'h200; ex_pred_taken_i = 0;
    #1 chk("br1.rpc", redirect_pc_o, 32'h200);
    cycle("br1");
    chk("br1.flush_one", 32'(flush_cnt_o), 1);
    ex_pred_taken_i = 1; ex_pred_pc_i = 32'h100; ex_br_target_i = 32'h104;
    #1 chk("br2.rpc", redirect_pc_o, 32'h104);
    cycle("br2");
    ex_br_taken_i = 0; ex_pc_i = 32'hFFFF_FFFC;
    #1 chk("br_wrap.rpc", redirect_pc_o, 32'h0);
    cycle("br_wrap");

    // data miss holds a pending mispredict for 4 cycles
    ex_br_taken_i = 1; ex_pred_taken_i = 0; ex_br_target_i = 32'h200;
    mem_req_i = 1; dmem_ready_i = 0;
    for (int i = 0; i < 4; i++) cycle("dmiss_br");
    dmem_ready_i = 1;
    cycle("dmiss_done");
    idle();

    // watchdog with 6 wait cycles
    do_reset();
    mem_req_i = 1; dmem_ready_i = 0;
    for (int i = 0; i < 3; i++) cycle("wd");
    chk("wd.not_yet", 32'(timeout_o), 0);
    cycle("wd");
    chk("wd.set", 32'(timeout_o), 1);
    cycle("wd"); cycle("wd");
    dmem_ready_i = 1;
    cycle("wd_ready");
    idle();
    cycle("wd_hold");
    chk("wd.sticky", 32'(timeout_o), 1);
    do_reset();
    chk("wd.cleared", 32'(timeout_o), 0);

    // fetch miss alone and under a load-use hazard
    imem_ready_i = 0;
    cycle("imiss");
    set_ldu(5'd5);
    cycle("imiss_ldu");
    idle();

    // stall counter saturation
    set_ldu(5'd7); id_rs2_i = 7;
    for (int i = 0; i < CMAX + 5; i++) cycle("sat");
    chk("sat.max", 32'(stall_cnt_o), CMAX);
    idle();

    // asynchronous reset in the middle of a data wait
    mem_req_i = 1; dmem_ready_i = 0;
    cycle("dw"); cycle("dw");
    #2 rst_i = 1; model_reset();
    #1;
    chk("arst.stall", 32'(stall_cnt_o), 0);
    chk("arst.flush", 32'(flush_cnt_o), 0);
    chk("arst.freeze", 32'(freeze_o), 0);
    cycle("arst");
    rst_i = 0;
    // state must restart from RUN: timeout only after 4 more miss cycles
    for (int i = 0; i < 3; i++) cycle("arst_dw");
    chk("arst.wd_restart", 32'(timeout_o), 0);
    idle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      id_rs1_i = 5'($urandom_range(0, 3)); id_rs2_i = 5'($urandom_range(0, 3));
      ex_rd_i  = 5'($urandom_range(0, 3));
      id_rs1_use_i = 1'($urandom); id_rs2_use_i = 1'($urandom);
      ex_is_load_i = ($urandom_range(0, 2) == 0);
      ex_br_valid_i = ($urandom_range(0, 2) == 0);
      ex_br_taken_i = 1'($urandom); ex_pred_taken_i = 1'($urandom);
      ex_br_target_i = 32'($urandom_range(0, 3)) << 2;
      ex_pred_pc_i   = 32'($urandom_range(0, 3)) << 2;
      ex_pc_i = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      mem_req_i = ($urandom_range(0, 2) == 0) || (n % 200 < 8);
      dmem_ready_i = (n % 200 < 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
      imem_ready_i = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 80) == 0) begin
        #2 rst_i = 1; model_reset();
        #1 chk_regs("rand_arst");
        cycle("rand_rst");
        rst_i = 0;
      end else begin
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the PC register enable and the IF/ID register enable and clear. It also freezes or bubbles the later stages for load-use hazards, branch mispredicts resolved in EX, instruction-fetch misses and multi-cycle data-memory accesses. It sits beside the datapath, takes hazard information from the ID, EX and MEM stages, and keeps saturating stall/flush counters plus a data-memory watchdog.

## Interface
- CNT_W, 16, width of the performance counters
- DMEM_TIMEOUT, 255, number of DWAIT cycles after which `timeout_o` sets; must be ≥ 1

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_rs1_i, id_rs2_i  in  5  source registers of the instruction in ID
- id_rs1_use_i, id_rs2_use_i  in  1  the ID instruction reads rs1 / rs2
- ex_rd_i  in  5  destination register of the instruction in EX
- ex_is_load_i  in  1  the EX instruction is a load
- ex_br_valid_i  in  1  the EX instruction is a branch or jump being resolved
- ex_br_taken_i  in  1  actual direction
- ex_br_target_i  in  32  actual taken target
- ex_pc_i  in  32  PC of the EX instruction
- ex_pred_taken_i  in  1  BTB prediction carried down the pipe
- ex_pred_pc_i  in  32  predicted next PC carried down the pipe
- mem_req_i  in  1  MEM stage has an active data access
- dmem_ready_i  in  1  data memory completes the access this cycle
- imem_ready_i  in  1  instruction memory returns a valid word this cycle
- pc_en_o  out  1  PC register load enable
- if_id_en_o  out  1  IF/ID enable
- if_id_flush_o  out  1  IF/ID synchronous clear to NOP (instr 0x00000013, pc 0, BTB bit 0, predicted PC 0); wins over `if_id_en_o`
- id_ex_flush_o  out  1  load a bubble into ID/EX
- freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- redirect_o  out  1  PC mux selects `redirect_pc_o`
- redirect_pc_o  out  32  corrected next PC
- stall_cnt_o  out  CNT_W  number of stall cycles
- flush_cnt_o  out  CNT_W  number of redirects
- timeout_o  out  1  sticky data-memory watchdog flag

## Operation
- FSM states: RUN and DWAIT. Registered state: FSM state, watchdog counter `wd` (width covering DMEM_TIMEOUT), both performance counters, `timeout_o`.
- `dmiss = mem_req_i & ~dmem_ready_i`.
- `mispred = ex_br_valid_i & ((ex_pred_taken_i != ex_br_taken_i) | (ex_br_taken_i & ex_pred_pc_i != ex_br_target_i))`.
- `ldu = ex_is_load_i & ex_rd_i != 0 & ((id_rs1_use_i & id_rs1_i == ex_rd_i) | (id_rs2_use_i & id_rs2_i == ex_rd_i))`.
- Per-cycle priority, evaluated combinationally; the first match applies:
  1. `dmiss`: `freeze_o=1`, `pc_en_o=0`, `if_id_en_o=0`, no flush, no redirect. A mispredict in the same cycle is ignored; the branch stays in EX and is re-evaluated after the freeze.
  2. `mispred`: `redirect_o=1`, `pc_en_o=1`, `if_id_flush_o=1`, `id_ex_flush_o=1`. `redirect_pc_o = ex_br_taken_i ? ex_br_target_i : ex_pc_i + 4`, with 32-bit modulo add (0xFFFFFFFC + 4 = 0).
  3. `ldu`: `pc_en_o=0`, `if_id_en_o=0`, `id_ex_flush_o=1`.
  4. `~imem_ready_i`: `pc_en_o=0`, `if_id_en_o=0`, `if_id_flush_o=1`. The IF/ID content still advances to ID/EX.
  5. Otherwise: `pc_en_o=1`, `if_id_en_o=1`, all other outputs 0.
- `redirect_pc_o = ex_pc_i + 4` whenever `redirect_o = 0`; its value is don't-care in that case.
- Transitions:
  - RUN → DWAIT on `dmiss`.
  - DWAIT → RUN in the cycle `dmem_ready_i` is high (no freeze that cycle).
  - DWAIT stays in DWAIT while `dmiss` holds. If `mem_req_i` drops while in DWAIT, return to RUN.
- Watchdog `wd`:
  - Cleared in RUN; increments each DWAIT cycle, saturating at DMEM_TIMEOUT.
  - `timeout_o` sets when `wd` reaches DMEM_TIMEOUT and holds until reset. The FSM keeps waiting.
- Counters:
  - `stall_cnt_o` += 1 each cycle with `freeze_o` or `ldu` stall or fetch bubble.
  - `flush_cnt_o` += 1 each `redirect_o` cycle.
  - Both saturate at 2^CNT_W − 1.

## Timing
- While `rst_i` is high, outputs are forced: `pc_en_o=0`, `if_id_en_o=0`, `if_id_flush_o=1`, `id_ex_flush_o=1`, `freeze_o=0`, `redirect_o=0`.
- Asynchronous reset values: state RUN, `wd=0`, `stall_cnt_o=0`, `flush_cnt_o=0`, `timeout_o=0`.
- Reset asserted mid-DWAIT returns to RUN immediately. Normal operation resumes on the first rising edge after deassertion.
- All control outputs are combinational from inputs with zero-cycle latency. Counters and the flag update on the edge that ends the cycle.
- A load-use stall lasts exactly 1 cycle when the pipeline is not otherwise stalled. The load leaves EX and `ldu` falls.
- Mispredict costs 2 bubbles: IF/ID and ID/EX become NOPs, and the fetch of `redirect_pc_o` occurs the next cycle.

## Test plan
- Load to x5 in EX, ID uses rs2=x5 → exactly one cycle of `pc_en_o=0`, `if_id_en_o=0`, `id_ex_flush_o=1`; `stall_cnt_o` = 1. Same case with rd = x0 → no stall.
- Predicted not-taken, actual taken to 0x200 → `redirect_o=1`, `redirect_pc_o=0x200`, both flushes high, `flush_cnt_o` = 1. Predicted taken to 0x100, actual 0x104 → redirect to 0x104.
- `mem_req_i=1`, `dmem_ready_i=0` for 4 cycles with a mispredict present → `freeze_o` high for 4 cycles and no redirect; on the ready cycle, redirect fires; state DWAIT then RUN.
- DMEM_TIMEOUT=3 with ready held low for 6 cycles → `timeout_o` rises after the 3rd DWAIT cycle and stays high after ready; `rst_i` clears it.
- `imem_ready_i=0` with `ldu` present → `ldu` priority applies (`id_ex_flush_o=1`, `if_id_flush_o=0`); with no hazard → `if_id_flush_o=1`, `pc_en_o=0`.
- CNT_W=2 with 5 stalls → `stall_cnt_o` saturates at 3. Assert `rst_i` mid-DWAIT → state RUN and counters 0 without waiting for a clock edge.
